// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver (8N1) feeding a first-word-fall-through
// byte FIFO, with framing-error pulse and sticky overrun/parity flags.
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames, parity checking).
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          UART_RX,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          clear_errors,
    output logic                          framing_error,
    output logic                          overrun,
    output logic                          parity_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic          r_rx_meta, r_rx_s;
    state_t        r_state, w_state_nx;
    logic [BW-1:0] r_baud, w_baud_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          w_push, w_ferr, r_ferr;
`ifdef UART_RX_PARITY_EN
    logic          r_par_bad, w_par_bad_nx, w_par_set, r_par_err;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovr;
    logic          w_full, w_pop, w_wr, w_ovr_set;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= UART_RX;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receiver state, baud/bit counters and shift register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_ferr  <= w_ferr;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nx;
`endif
        end
    end

    // Frame decoding: half-bit start check, then one sample per bit centre.
    // STOP returns to IDLE at the stop-bit centre so back-to-back frames work.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_push     = 1'b0;
        w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nx = r_par_bad;
        w_par_set    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_nx = '0;
                w_bit_nx  = '0;
`ifdef UART_RX_PARITY_EN
                w_par_bad_nx = 1'b0;
`endif
                if (!r_rx_s) w_state_nx = S_START;
            end
            S_START: begin
                if (r_baud == HALF_M1) begin
                    w_baud_nx  = '0;
                    w_state_nx = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nx  = '0;
                    w_shift_nx = {r_rx_s, r_shift[7:1]};
                    w_bit_nx   = r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (r_bit == 3'd7) w_state_nx = S_PARITY;
`else
                    if (r_bit == 3'd7) w_state_nx = S_STOP;
`endif
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nx    = '0;
                    w_par_bad_nx = ^{r_shift, r_rx_s};
                    w_par_set    = ^{r_shift, r_rx_s};
                    w_state_nx   = S_STOP;
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
`endif
            S_STOP: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nx = '0;
                    if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = !r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr     = 1'b1;
                        w_state_nx = S_BREAK;
                    end
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
            S_BREAK: begin
                // Line held low past the stop bit: wait for idle before re-arming.
                if (r_rx_s) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = rd_en && (r_count != '0);
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    // FIFO storage; contents are only observable through rd_data when non-empty.
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    // FIFO pointers, occupancy and sticky error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovr_set)         r_ovr <= 1'b1;
            else if (clear_errors) r_ovr <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag; a new error in the clearing cycle still sets it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          r_par_err <= 1'b0;
        else if (w_par_set)    r_par_err <= 1'b1;
        else if (clear_errors) r_par_err <= 1'b0;
    end
    assign parity_error = r_par_err;
`else
    assign parity_error = 1'b0;
`endif

    assign rd_valid      = (r_count != '0);
    assign rd_data       = rd_valid ? r_mem[r_rptr] : 8'h00;
    assign fifo_count    = r_count;
    assign framing_error = r_ferr;
    assign overrun       = r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=8, FIFO_DEPTH=16.
module tb_uart_rx_fifo;
    localparam int CPB   = 8;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       UART_RX = 1'b1;
    logic       rd_en = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] fifo_count;
    logic       framing_error, overrun, parity_error;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    logic v_pre = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [4:0] exp_count;
        logic [7:0] exp_head;
        logic       exp_ovr;
    } vec_t;
    vec_t tbl [17];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .UART_RX(UART_RX), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .clear_errors(clear_errors), .framing_error(framing_error),
        .overrun(overrun), .parity_error(parity_error)
    );

    always #5 clock = ~clock;

    // Counts cycles with framing_error high, so a single pulse adds exactly 1.
    always @(posedge clock) if (framing_error === 1'b1) ferr_cnt <= ferr_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the first nb bit periods of a frame from negedges. Parity is even
    // parity of d, inverted when pflip. At the second-to-last cycle of a full
    // frame rd_valid is captured and, if requested, rd_en spans the stop sample.
    task automatic send(input logic [7:0] d, input logic stop, input logic pflip,
                        input int nb, input logic pop_at_stop);
        logic [10:0] fr;
        fr = 11'h7FF;
        fr[0]   = 1'b0;
        fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
        fr[9]  = (^d) ^ pflip;
        fr[10] = stop;
`else
        fr[9]  = stop;
        fr[10] = pflip | 1'b1;
`endif
        for (int k = 0; k < nb * CPB; k++) begin
            @(negedge clock);
            UART_RX = fr[k / CPB];
            if (k == NB * CPB - 2) begin
                v_pre = rd_valid;
                if (pop_at_stop) rd_en = 1'b1;
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            UART_RX = 1'b1;
        end
    endtask

    task automatic pop();
        @(negedge clock);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    initial begin
        int f0;
        for (int i = 0; i < 17; i++) begin
            tbl[i].data      = 8'(i);
            tbl[i].exp_count = (i < 16) ? 5'(i + 1) : 5'd16;
            tbl[i].exp_head  = 8'h00;
            tbl[i].exp_ovr   = (i == 16);
        end

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", framing_error, 0);
        chk("rst_par", parity_error, 0);
        reset_n = 1'b1;
        idle(4);

        // Single byte and latency
        send(8'h55, 1'b1, 1'b0, NB, 1'b0);
        chk("lat_pre_valid", v_pre, 0);
        chk("lat_valid", rd_valid, 1);
        chk("b55_data", rd_data, 8'h55);
        chk("b55_count", fifo_count, 1);
        pop();
        chk("b55_pop_valid", rd_valid, 0);
        chk("b55_pop_count", fifo_count, 0);
        idle(4);

        // 3-cycle glitch on an idle line
        f0 = ferr_cnt;
        repeat (3) begin
            @(negedge clock);
            UART_RX = 1'b0;
        end
        idle(12);
        chk("glitch_count", fifo_count, 0);
        chk("glitch_valid", rd_valid, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);

        // Framing error followed by a break, then a good byte
        f0 = ferr_cnt;
        send(8'hA5, 1'b0, 1'b0, NB, 1'b0);
        repeat (20) begin
            @(negedge clock);
            UART_RX = 1'b0;
        end
        idle(4);
        send(8'h3C, 1'b1, 1'b0, NB, 1'b0);
        idle(4);
        chk("ferr_pulses", ferr_cnt - f0, 1);
        chk("ferr_count", fifo_count, 1);
        chk("ferr_data", rd_data, 8'h3C);
        pop();
        idle(2);

        // Fill past full: table of 17 bytes, no reads
        for (int i = 0; i < 17; i++) begin
            send(tbl[i].data, 1'b1, 1'b0, NB, 1'b0);
            idle(2);
            chk($sformatf("fill%0d_count", i), fifo_count, tbl[i].exp_count);
            chk($sformatf("fill%0d_valid", i), rd_valid, 1);
            chk($sformatf("fill%0d_head", i), rd_data, tbl[i].exp_head);
            chk($sformatf("fill%0d_ovr", i), overrun, tbl[i].exp_ovr);
        end
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain%0d", j), rd_data, j);
            pop();
        end
        chk("drain_valid", rd_valid, 0);
        chk("drain_ovr_sticky", overrun, 1);
        @(negedge clock);
        clear_errors = 1'b1;
        @(negedge clock);
        clear_errors = 1'b0;
        chk("clr_ovr", overrun, 0);

        // Full FIFO with a pop in the push cycle
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h20 + i), 1'b1, 1'b0, NB, 1'b0);
            idle(2);
        end
        chk("full_count", fifo_count, 16);
        send(8'h77, 1'b1, 1'b0, NB, 1'b1);
        idle(2);
        chk("fullpop_count", fifo_count, 16);
        chk("fullpop_ovr", overrun, 0);
        chk("fullpop_head", rd_data, 8'h21);
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("fp_drain%0d", j), rd_data, 8'h21 + j);
            pop();
        end
        chk("fp_last", rd_data, 8'h77);
        pop();
        chk("fp_empty", rd_valid, 0);
        idle(2);

        // Reset mid-frame
        send(8'h11, 1'b1, 1'b0, NB, 1'b0);
        idle(2);
        chk("pre_rst_count", fifo_count, 1);
        send(8'hFF, 1'b1, 1'b0, 5, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        UART_RX = 1'b1;
        #1;
        chk("midrst_count", fifo_count, 0);
        chk("midrst_valid", rd_valid, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        idle(4);
        send(8'h81, 1'b1, 1'b0, NB, 1'b0);
        idle(2);
        chk("post_rst_count", fifo_count, 1);
        chk("post_rst_data", rd_data, 8'h81);
        pop();
        chk("post_rst_empty", rd_valid, 0);
        idle(2);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, NB, 1'b0);
        idle(2);
        chk("par_bad_flag", parity_error, 1);
        chk("par_bad_count", fifo_count, 0);
        send(8'h07, 1'b1, 1'b0, NB, 1'b0);
        idle(2);
        chk("par_ok_count", fifo_count, 1);
        chk("par_ok_data", rd_data, 8'h07);
        chk("par_ok_flag", parity_error, 1);
`else
        chk("par_tied", parity_error, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
